// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared keyboard constants and the auto-repeat state type
//                used by the keycode front end and its consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

  // USB HID usage codes of the keys the game reacts to
  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_ESC   = 8'd41;
  localparam logic [7:0] KEY_W     = 8'd26;
  localparam logic [7:0] KEY_A     = 8'd4;
  localparam logic [7:0] KEY_S     = 8'd22;
  localparam logic [7:0] KEY_D     = 8'd7;

  // Auto-repeat state of the currently held key
  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } repeat_state_t;

endpackage
`default_nettype wire

// File: rtl/keycode_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keycode_debounce
//  Description : Registers the raw PIO keycode and only passes a value on
//                once it has been sampled DEBOUNCE_CYCLES times in a row.
//  Revision    : 1.0 - initial release
// ============================================================================
module keycode_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [7:0] Keycode_raw,
  output logic [7:0] Stable
);

  localparam int             CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_ACCEPT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       r_samp;
  logic [7:0]       r_cand;
  logic [7:0]       r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       w_cand_next;
  logic [CNT_W-1:0] w_cnt_next;

  // Candidate tracking: restart the run on any change, otherwise count up and saturate
  always_comb begin
    w_cand_next = r_cand;
    w_cnt_next  = r_cnt;
    if (r_samp != r_cand) begin
      w_cand_next = r_samp;
      w_cnt_next  = '0;
    end else if (r_cnt != C_CNT_MAX) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Sample register, run counter and accepted value; acceptance happens on the
  // edge the run reaches its full length so a single-sample debounce also works
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_samp   <= KEY_NONE;
      r_cand   <= KEY_NONE;
      r_cnt    <= '0;
      r_stable <= KEY_NONE;
    end else begin
      r_samp <= Keycode_raw;
      r_cand <= w_cand_next;
      r_cnt  <= w_cnt_next;
      if (w_cnt_next == C_CNT_ACCEPT) begin
        r_stable <= w_cand_next;
      end
    end
  end

  assign Stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : key_event_gen
//  Description : Debounced held keycode plus single-cycle press, release and
//                auto-repeat events for the game FSM and movement logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_event_gen
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [7:0] Keycode_raw,
  output logic [7:0] Keycode,
  output logic       Key_valid,
  output logic       Key_press,
  output logic [7:0] Press_code,
  output logic       Key_release,
  output logic [7:0] Release_code,
  output logic       Key_repeat
);

  localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W   = (RCNT_MAX <= 1) ? 1 : $clog2(RCNT_MAX);
  localparam logic [RCNT_W-1:0] C_DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] C_PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
  localparam logic [RCNT_W-1:0] C_RCNT_SAT    = '1;

  logic [7:0]        w_stable;
  logic              w_change;
  logic              w_press;
  logic              w_release;
  logic              w_repeat_fire;
  logic [RCNT_W-1:0] w_rcnt_inc;

  logic [7:0]        r_keycode;
  logic              r_key_valid;
  logic              r_key_press;
  logic [7:0]        r_press_code;
  logic              r_key_release;
  logic [7:0]        r_release_code;
  logic              r_key_repeat;

  repeat_state_t     r_state;
  repeat_state_t     w_state_next;
  logic [RCNT_W-1:0] r_rcnt;
  logic [RCNT_W-1:0] w_rcnt_next;

  keycode_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Keycode_raw (Keycode_raw),
    .Stable      (w_stable)
  );

  // The held keycode register doubles as the "previous" value for edge detection,
  // so an X->Y change yields release(X) and press(Y) on the same edge
  assign w_change   = (w_stable != r_keycode);
  assign w_press    = w_change && (w_stable != KEY_NONE);
  assign w_release  = w_change && (r_keycode != KEY_NONE);
  assign w_rcnt_inc = (r_rcnt == C_RCNT_SAT) ? r_rcnt : r_rcnt + 1'b1;

  // Event and held-code registers; everything updates on the same edge as the pulses
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_keycode      <= KEY_NONE;
      r_key_valid    <= 1'b0;
      r_key_press    <= 1'b0;
      r_press_code   <= KEY_NONE;
      r_key_release  <= 1'b0;
      r_release_code <= KEY_NONE;
      r_key_repeat   <= 1'b0;
    end else begin
      r_keycode     <= w_stable;
      r_key_valid   <= (w_stable != KEY_NONE);
      r_key_press   <= w_press;
      r_key_release <= w_release;
      r_key_repeat  <= w_repeat_fire;
      if (w_press) begin
        r_press_code <= w_stable;
      end
      if (w_release) begin
        r_release_code <= r_keycode;
      end
    end
  end

  // Repeat FSM state and interval counter
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= R_IDLE;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_rcnt  <= w_rcnt_next;
    end
  end

  // Repeat FSM next state: a new press (including X->Y) restarts the delay,
  // a plain release parks the machine
  always_comb begin
    w_state_next = r_state;
    w_rcnt_next  = r_rcnt;
    case (r_state)
      R_IDLE: begin
        w_rcnt_next = '0;
        if (w_press) begin
          w_state_next = R_DELAY;
        end
      end
      R_DELAY: begin
        if (w_change) begin
          w_state_next = w_press ? R_DELAY : R_IDLE;
          w_rcnt_next  = '0;
        end else if (r_rcnt == C_DELAY_LAST) begin
          w_state_next = R_REPEAT;
          w_rcnt_next  = '0;
        end else begin
          w_rcnt_next = w_rcnt_inc;
        end
      end
      R_REPEAT: begin
        if (w_change) begin
          w_state_next = w_press ? R_DELAY : R_IDLE;
          w_rcnt_next  = '0;
        end else if (r_rcnt == C_PERIOD_LAST) begin
          w_rcnt_next = '0;
        end else begin
          w_rcnt_next = w_rcnt_inc;
        end
      end
      default: begin
        w_state_next = R_IDLE;
        w_rcnt_next  = '0;
      end
    endcase
    if (!REPEAT_EN) begin
      w_state_next = R_IDLE;
      w_rcnt_next  = '0;
    end
  end

  // Repeat FSM output: fire at the end of each interval unless the key changes this cycle
  always_comb begin
    w_repeat_fire = 1'b0;
    if (!w_change) begin
      if ((r_state == R_DELAY) && (r_rcnt == C_DELAY_LAST)) begin
        w_repeat_fire = 1'b1;
      end else if ((r_state == R_REPEAT) && (r_rcnt == C_PERIOD_LAST)) begin
        w_repeat_fire = 1'b1;
      end
    end
  end

  assign Keycode      = r_keycode;
  assign Key_valid    = r_key_valid;
  assign Key_press    = r_key_press;
  assign Press_code   = r_press_code;
  assign Key_release  = r_key_release;
  assign Release_code = r_release_code;
  assign Key_repeat   = r_key_repeat;

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_event_gen
//  Description : Bench for key_event_gen: one instance with auto-repeat, one
//                without, both compared each cycle against a window/time
//                based reference model, plus directed scenario checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_gen;
  import game_pkg::*;

  localparam int D  = 4;
  localparam int DL = 20;
  localparam int PR = 5;
  localparam int HMAX = 8192;

  logic       Clock;
  logic       Reset_n;
  logic [7:0] raw  [2];
  logic [7:0] kc   [2];
  logic       kv   [2];
  logic       kp   [2];
  logic [7:0] pc   [2];
  logic       kr   [2];
  logic [7:0] rc   [2];
  logic       krep [2];

  int n_tests = 0;
  int n_fail  = 0;

  key_event_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DL), .REPEAT_PERIOD(PR), .REPEAT_EN(1'b1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Keycode_raw(raw[0]), .Keycode(kc[0]), .Key_valid(kv[0]),
    .Key_press(kp[0]), .Press_code(pc[0]), .Key_release(kr[0]), .Release_code(rc[0]), .Key_repeat(krep[0]));

  key_event_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DL), .REPEAT_PERIOD(PR), .REPEAT_EN(1'b0)) dut_norep (
    .Clock(Clock), .Reset_n(Reset_n), .Keycode_raw(raw[1]), .Keycode(kc[1]), .Key_valid(kv[1]),
    .Key_press(kp[1]), .Press_code(pc[1]), .Key_release(kr[1]), .Release_code(rc[1]), .Key_repeat(krep[1]));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  // A code is held once the D raw samples ending two edges ago all agree;
  // repeats occur at press+DL+k*PR while the same key stays held.
  logic [7:0] hist [0:1][0:HMAX-1];
  int         hn   [2];
  logic [7:0] m_key [2];
  logic [7:0] m_pc  [2];
  logic [7:0] m_rc  [2];
  logic       m_p   [2];
  logic       m_r   [2];
  logic       m_rep [2];
  int         pedge [2];
  logic       m_en  [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hn[i] = 0; m_key[i] = 8'h00; m_pc[i] = 8'h00; m_rc[i] = 8'h00;
      m_p[i] = 1'b0; m_r[i] = 1'b0; m_rep[i] = 1'b0; pedge[i] = -1;
    end
  endtask

  task automatic model_edge(input int i, input logic [7:0] r);
    int e;
    logic [7:0] nk;
    logic same;
    if (hn[i] < HMAX) begin
      hist[i][hn[i]] = r;
      hn[i] = hn[i] + 1;
    end
    e  = hn[i];
    nk = m_key[i];
    if (e >= D + 2) begin
      same = 1'b1;
      for (int k = e - 2 - D; k <= e - 3; k++)
        if (hist[i][k] !== hist[i][e-3]) same = 1'b0;
      if (same) nk = hist[i][e-3];
    end
    m_p[i] = (nk != m_key[i]) && (nk != 8'h00);
    m_r[i] = (nk != m_key[i]) && (m_key[i] != 8'h00);
    if (m_p[i]) begin m_pc[i] = nk; pedge[i] = e; end
    if (m_r[i]) m_rc[i] = m_key[i];
    if ((nk != m_key[i]) && (nk == 8'h00)) pedge[i] = -1;
    m_rep[i] = m_en[i] && !m_p[i] && (pedge[i] >= 0) && ((e - pedge[i]) >= DL)
               && (((e - pedge[i] - DL) % PR) == 0);
    m_key[i] = nk;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.Keycode", i),      {24'd0, kc[i]},   {24'd0, m_key[i]});
      chk($sformatf("u%0d.Key_valid", i),    {31'd0, kv[i]},   {31'd0, m_key[i] != 8'h00});
      chk($sformatf("u%0d.Key_press", i),    {31'd0, kp[i]},   {31'd0, m_p[i]});
      chk($sformatf("u%0d.Press_code", i),   {24'd0, pc[i]},   {24'd0, m_pc[i]});
      chk($sformatf("u%0d.Key_release", i),  {31'd0, kr[i]},   {31'd0, m_r[i]});
      chk($sformatf("u%0d.Release_code", i), {24'd0, rc[i]},   {24'd0, m_rc[i]});
      chk($sformatf("u%0d.Key_repeat", i),   {31'd0, krep[i]}, {31'd0, m_rep[i]});
    end
  endtask

  // One clock: advance the model with the values present at the edge, then check
  task automatic tick();
    @(posedge Clock);
    if (Reset_n) begin
      model_edge(0, raw[0]);
      model_edge(1, raw[1]);
    end
    #1;
    check_outputs();
  endtask

  // Ticks until the selected pulse (0 press, 1 release, 2 repeat) shows; -1 if the budget expires
  task automatic wait_pulse(input int which, input int inst, input int limit, output int n);
    logic s;
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      tick();
      s = (which == 0) ? kp[inst] : (which == 1) ? kr[inst] : krep[inst];
      if (s) begin
        n = k;
        break;
      end
    end
  endtask

  logic [7:0] keys [7];
  int lat, cnt_p, cnt_r, cnt_rep;

  initial begin
    keys[0] = KEY_NONE; keys[1] = KEY_A; keys[2] = KEY_D; keys[3] = KEY_S;
    keys[4] = KEY_W; keys[5] = KEY_ESC; keys[6] = KEY_SPACE;
    m_en[0] = 1'b1; m_en[1] = 1'b0;
    model_reset();
    raw[0] = KEY_SPACE; raw[1] = KEY_NONE;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;

    // 1: reset with a key held, then first press after the debounce latency
    repeat (3) tick();
    @(negedge Clock); Reset_n = 1'b1;
    wait_pulse(0, 0, 20, lat);
    chk("t1.press_latency", lat, D + 2);
    chk("t1.press_code", {24'd0, pc[0]}, {24'd0, KEY_SPACE});
    tick();
    chk("t1.keycode", {24'd0, kc[0]}, {24'd0, KEY_SPACE});
    chk("t1.key_valid", {31'd0, kv[0]}, 32'd1);

    // 2: short glitch is rejected
    raw[0] = KEY_NONE;
    repeat (10) tick();
    raw[0] = KEY_W;
    cnt_p = 0;
    repeat (3) begin tick(); cnt_p += kp[0]; end
    raw[0] = KEY_NONE;
    repeat (10) begin tick(); cnt_p += kp[0]; end
    chk("t2.glitch_presses", cnt_p, 0);
    chk("t2.keycode", {24'd0, kc[0]}, 32'd0);

    // 3: hold D key, repeat cadence
    raw[0] = KEY_D;
    wait_pulse(0, 0, 20, lat);
    chk("t3.press_latency", lat, D + 2);
    cnt_rep = krep[0];
    repeat (39) begin tick(); cnt_rep += krep[0]; end
    chk("t3.repeats_in_40", cnt_rep, 4);

    // 4: switch D -> A, simultaneous release/press, delay restarts
    raw[0] = KEY_A;
    wait_pulse(1, 0, 20, lat);
    chk("t4.change_latency", lat, D + 2);
    chk("t4.press_same_cycle", {31'd0, kp[0]}, 32'd1);
    chk("t4.release_code", {24'd0, rc[0]}, {24'd0, KEY_D});
    chk("t4.press_code", {24'd0, pc[0]}, {24'd0, KEY_A});
    wait_pulse(2, 0, 40, lat);
    chk("t4.first_repeat_after", lat, DL);

    // 5: reset in the middle of a held ESC key
    raw[0] = KEY_NONE;
    repeat (8) tick();
    raw[0] = KEY_ESC;
    wait_pulse(0, 0, 20, lat);
    chk("t5.press_latency", lat, D + 2);
    wait_pulse(2, 0, 30, lat);
    chk("t5.first_repeat", lat, DL);
    repeat (2) tick();
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    chk("t5.async_keycode", {24'd0, kc[0]}, 32'd0);
    chk("t5.async_valid", {31'd0, kv[0]}, 32'd0);
    chk("t5.async_press_code", {24'd0, pc[0]}, 32'd0);
    chk("t5.async_repeat", {31'd0, krep[0]}, 32'd0);
    cnt_r = 0;
    tick();
    @(negedge Clock); Reset_n = 1'b1;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      cnt_r += kr[0];
      if (kp[0] && lat < 0) lat = k;
    end
    chk("t5.press_after_reset", lat, D + 2);
    chk("t5.no_release", cnt_r, 0);
    chk("t5.press_code", {24'd0, pc[0]}, {24'd0, KEY_ESC});

    // 6: no-repeat instance, long hold then release
    raw[0] = KEY_NONE;
    raw[1] = KEY_S;
    cnt_p = 0; cnt_rep = 0;
    repeat (100) begin tick(); cnt_p += kp[1]; cnt_rep += krep[1]; end
    chk("t6.presses", cnt_p, 1);
    chk("t6.repeats", cnt_rep, 0);
    raw[1] = KEY_NONE;
    cnt_r = 0;
    repeat (15) begin tick(); cnt_r += kr[1]; end
    chk("t6.releases", cnt_r, 1);
    chk("t6.release_code", {24'd0, rc[1]}, {24'd0, KEY_S});

    // Random holds on both instances, checked every cycle by the model
    for (int s = 0; s < 60; s++) begin
      raw[0] = keys[$urandom_range(0, 6)];
      raw[1] = keys[$urandom_range(0, 6)];
      repeat ($urandom_range(1, 32)) tick();
    end
    raw[0] = KEY_NONE; raw[1] = KEY_NONE;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
